data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the single-cycle processor's data port. It serves `WE`, `address_to_mem`, `data_to_mem` and `data_from_mem` with a word RAM and a small memory-mapped I/O page:

- a free-running cycle counter
- a GPIO output register
- a byte transmit FIFO drained through a ready/valid handshake
- a status register with sticky error flags

Reads are combinational so a load completes in the same cycle; writes commit on the clock edge.

## Interface
- `RAM_WORDS`, 64, RAM depth in 32-bit words; power of two, ≥4.
- `IO_BASE`, 32'h0000_1000, base of the 16-byte I/O page; 16-byte aligned, ≥ RAM_WORDS*4.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, 2..8.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `WE`  in  1  write enable from the processor.
- `address_to_mem`  in  32  byte address of the access.
- `data_to_mem`  in  32  write data.
- `data_from_mem`  out  32  read data; combinational.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head byte this cycle.
- `gpio_out`  out  32  GPIO register.

## Operation
**Address decode.** Word offset is `address_to_mem[3:2]` within the I/O page.
- RAM: `address_to_mem < RAM_WORDS*4`. Word index is `address_to_mem[log2(RAM_WORDS)+1:2]`.
- I/O page: `IO_BASE <= address_to_mem < IO_BASE+16`.
  - Offset 0x0 CYCLE (R/W).
  - Offset 0x4 GPIO (R/W).
  - Offset 0x8 TXDATA (W; reads 0).
  - Offset 0xC STATUS (R, W1C).
- Anything else is unmapped: reads return 0, writes are ignored.

**Alignment.**
- Reads ignore `address_to_mem[1:0]`. The processor drives the ALU result every cycle, so reads never flag errors.
- A write with `address_to_mem[1:0] != 0` is suppressed in every region and sets the sticky MISALIGN flag.

**RAM.**
- Write when `WE` is high, the address is aligned and `reset` is low.
- RAM contents are not reset.

**CYCLE.**
- Increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
- A write loads `data_to_mem` in place of the increment.

**GPIO.** A write loads `data_to_mem`; the value appears on `gpio_out`.

**TXDATA.**
- A write pushes `data_to_mem[7:0]` if the FIFO is not full.
- If the FIFO is full, the byte is dropped and the sticky OVERFLOW flag is set.

**STATUS read.**
- bit0 empty
- bit1 full
- bits[7:4] count
- bit8 MISALIGN
- bit9 OVERFLOW
- other bits 0

**STATUS write.**
- `data_to_mem[8]=1` clears MISALIGN; `data_to_mem[9]=1` clears OVERFLOW.
- If a flag is set and cleared in the same cycle, set wins.

**FIFO.**
- Circular buffer with read pointer, write pointer and count.
- `tx_data` shows the head entry; `tx_valid` = count≠0.
- Pop occurs when `tx_valid & tx_ready`.
- Full is judged from the pre-edge count. A push while full is dropped even if a pop happens in the same cycle.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
**Reset.** While `reset`=1, the following are forced at the edge:
- CYCLE=0, `gpio_out`=0, FIFO count=0, pointers=0
- `tx_valid`=0, MISALIGN=0, OVERFLOW=0
- all writes and pops ignored

**Reset mid-operation.** Reset discards queued FIFO bytes; the byte presented on `tx_data` in the reset cycle is not considered consumed.

**Read latency.** 0 cycles: `data_from_mem` follows the address combinationally.

**Write visibility.** A write on edge N is visible to reads in cycle N+1.

**CYCLE reads.**
- Read in cycle k after reset deassertion returns k; the first cycle with `reset` low reads 0.
- After a write of V on edge N, a read in cycle N+1 returns V and in cycle N+2 returns V+1.

**FIFO latency.** A push on edge N raises `tx_valid` in cycle N+1. There is no bypass from a push to `tx_data` in the same cycle.

## Test plan
- **RAM round-trip.** Reset, write 32'hDEADBEEF at 0x10 -> read 0x10 returns DEADBEEF next cycle; reads of 0x11/0x13 also return DEADBEEF; 0x14 is unaffected.
- **Misaligned write.** Write 32'h12345678 to 0x22 -> RAM word 0x20 unchanged, STATUS bit8=1. Write 32'h100 to STATUS -> bit8=0 next cycle.
- **Counter.**
  - Deassert reset, hold 5 cycles, read CYCLE -> 5.
  - Write 32'hFFFF_FFFE -> reads FFFF_FFFE, FFFF_FFFF, then 0.
- **FIFO fill with tx_ready=0.** Push 0x41..0x45 -> bytes 0x41..0x44 queued; STATUS reads full=1, count=4, OVERFLOW=1. Raise `tx_ready` -> `tx_data` emits 0x41, 0x42, 0x43, 0x44 on consecutive cycles, then `tx_valid`=0.
- **Simultaneous push/pop.** With count=2 and `tx_ready`=1, push 0x55 -> count stays 2 and 0x55 is emitted in order. With count=4 and a pop in the same cycle, push 0x66 -> dropped, OVERFLOW=1, count=3.
- **Reset and unmapped.**
  - Reset mid-stream with count=3 -> `tx_valid`=0, `gpio_out`=0 in the next cycle.
  - Read 0x0000_2000 -> 0.
  - Write 0x0000_2000 -> no state change.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM plus I/O page (cycle counter, GPIO, TX byte FIFO, sticky status) for a single-cycle CPU data port.
module data_mem_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] gpio_out
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [31:0]   cycle;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          misalign, overflow;

  logic        in_ram, in_io, aligned, wr, full, empty, push, pop;
  logic        cyc_wr, gpio_wr, tx_wr, st_wr;
  logic [1:0]  off;
  logic [31:0] status, io_rd;

  always_comb begin
    in_ram  = address_to_mem < RAM_BYTES;
    in_io   = address_to_mem[31:4] == IO_BASE[31:4];
    off     = address_to_mem[3:2];
    aligned = address_to_mem[1:0] == 2'b00;
    wr      = WE & aligned;
    cyc_wr  = wr & in_io & (off == 2'd0);
    gpio_wr = wr & in_io & (off == 2'd1);
    tx_wr   = wr & in_io & (off == 2'd2);
    st_wr   = wr & in_io & (off == 2'd3);
    empty   = count == '0;
    full    = count == FULL_COUNT;
    push    = tx_wr & ~full;
    pop     = tx_valid & tx_ready;
    status  = {22'b0, overflow, misalign, 4'(count), 2'b0, full, empty};
    io_rd   = off == 2'd0 ? cycle : off == 2'd1 ? gpio_out : off == 2'd2 ? 32'b0 : status;
    data_from_mem = in_ram ? ram[address_to_mem[AW+1:2]] : in_io ? io_rd : 32'b0;
    tx_valid = ~empty;
    tx_data  = fifo[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle    <= '0;
      gpio_out <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      misalign <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cycle    <= cyc_wr ? data_to_mem : cycle + 32'd1;
      gpio_out <= gpio_wr ? data_to_mem : gpio_out;
      wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      // a set and a clear landing together resolve to set
      misalign <= (WE & ~aligned) | (misalign & ~(st_wr & data_to_mem[8]));
      overflow <= (tx_wr & full) | (overflow & ~(st_wr & data_to_mem[9]));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr & in_ram) ram[address_to_mem[AW+1:2]] <= data_to_mem;
      if (push) fifo[wr_ptr] <= data_to_mem[7:0];
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed literal checks plus randomized traffic against a queue-based behavioural model.
module tb_data_mem_responder;
  localparam logic [31:0] IO  = 32'h0000_1000;
  localparam logic [31:0] CYC = IO + 32'h0, GPIO = IO + 32'h4, TX = IO + 32'h8, ST = IO + 32'hC;
  localparam int FD = 4;

  logic        clk = 1'b0, reset = 1'b1, WE = 1'b0, tx_ready = 1'b0;
  logic [31:0] address_to_mem = '0, data_to_mem = '0;
  logic [31:0] data_from_mem, gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        nx_reset = 1'b1, nx_ready = 1'b0;

  int compared = 0, mismatched = 0;

  logic [31:0] m_ram [64];
  bit          m_valid [64];
  logic [31:0] m_cycle, m_gpio;
  logic [7:0]  m_q [$];
  bit          m_mis, m_ovf, live = 0;

  data_mem_responder dut (
    .clk(clk), .reset(reset), .WE(WE), .address_to_mem(address_to_mem),
    .data_to_mem(data_to_mem), .data_from_mem(data_from_mem), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic put(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset = nx_reset; tx_ready = nx_ready; WE = w; address_to_mem = a; data_to_mem = d;
    #1;
  endtask

  function automatic logic [31:0] m_status();
    return {22'b0, m_ovf, m_mis, 4'(m_q.size()), 2'b0, m_q.size() == FD, m_q.size() == 0};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'd256) return m_ram[a[7:2]];
    if (a[31:4] != IO[31:4]) return 32'b0;
    case (a[3:2])
      2'd0: return m_cycle;
      2'd1: return m_gpio;
      2'd2: return 32'b0;
      default: return m_status();
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] a;
    bit al, io, full, pop, pr, stc;
    a = address_to_mem;
    al = a[1:0] == 2'b00;
    io = a[31:4] == IO[31:4];
    if (reset) begin
      m_cycle = 0; m_gpio = 0; m_q.delete(); m_mis = 0; m_ovf = 0; live = 1;
    end else begin
      full = m_q.size() == FD;
      pop  = m_q.size() != 0 && tx_ready;
      pr   = WE && al && io && a[3:2] == 2'd2;
      stc  = WE && al && io && a[3:2] == 2'd3;
      if (WE && al && a < 32'd256) begin m_ram[a[7:2]] = data_to_mem; m_valid[a[7:2]] = 1; end
      m_cycle = (WE && al && io && a[3:2] == 2'd0) ? data_to_mem : m_cycle + 1;
      if (WE && al && io && a[3:2] == 2'd1) m_gpio = data_to_mem;
      if (WE && !al) m_mis = 1; else if (stc && data_to_mem[8]) m_mis = 0;
      if (pr && full) m_ovf = 1; else if (stc && data_to_mem[9]) m_ovf = 0;
      if (pop) void'(m_q.pop_front());
      if (pr && !full) m_q.push_back(data_to_mem[7:0]);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      if (address_to_mem >= 32'd256 || m_valid[address_to_mem[7:2]])
        chk("model_read", data_from_mem, m_read(address_to_mem));
      chk("model_gpio", gpio_out, m_gpio);
      chk("model_tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("model_tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
    end
  end

  initial begin
    logic [31:0] a;
    int r;
    put(0, ST, 0);
    put(0, ST, 0);
    chk("reset_status", data_from_mem, 32'h1);
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_valid", {31'b0, tx_valid}, 32'h0);
    nx_reset = 0;
    put(0, CYC, 0);
    chk("cycle_0", data_from_mem, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      put(0, CYC, 0);
      chk("cycle_k", data_from_mem, 32'(k));
    end
    put(1, 32'h14, 32'h0BAD_F00D);
    put(1, 32'h10, 32'hDEAD_BEEF);
    put(0, 32'h10, 0); chk("ram_10", data_from_mem, 32'hDEAD_BEEF);
    put(0, 32'h11, 0); chk("ram_11", data_from_mem, 32'hDEAD_BEEF);
    put(0, 32'h13, 0); chk("ram_13", data_from_mem, 32'hDEAD_BEEF);
    put(0, 32'h14, 0); chk("ram_14", data_from_mem, 32'h0BAD_F00D);
    put(1, 32'h20, 32'hAAAA_5555);
    put(1, 32'h22, 32'h1234_5678);
    put(0, 32'h20, 0); chk("misalign_ram", data_from_mem, 32'hAAAA_5555);
    put(0, ST, 0); chk("misalign_set", data_from_mem, 32'h101);
    put(1, ST, 32'h100);
    put(0, ST, 0); chk("misalign_clr", data_from_mem, 32'h1);
    put(1, CYC, 32'hFFFF_FFFE);
    put(0, CYC, 0); chk("cyc_load", data_from_mem, 32'hFFFF_FFFE);
    put(0, CYC, 0); chk("cyc_max", data_from_mem, 32'hFFFF_FFFF);
    put(0, CYC, 0); chk("cyc_wrap", data_from_mem, 32'h0);
    for (int i = 0; i < 5; i++) put(1, TX, 32'h41 + 32'(i));
    put(0, ST, 0); chk("fifo_full_status", data_from_mem, 32'h242);
    chk("fifo_head", {24'b0, tx_data}, 32'h41);
    nx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      put(0, 32'h2000, 0);
      chk("drain_data", {24'b0, tx_data}, 32'h41 + 32'(i));
      chk("drain_valid", {31'b0, tx_valid}, 32'h1);
    end
    put(0, ST, 0);
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);
    chk("drained_status", data_from_mem, 32'h201);
    put(1, ST, 32'h200);
    put(0, ST, 0); chk("ovf_clr", data_from_mem, 32'h1);
    nx_ready = 0;
    put(1, TX, 32'h11);
    put(1, TX, 32'h22);
    nx_ready = 1;
    put(1, TX, 32'h55); chk("pp_head", {24'b0, tx_data}, 32'h11);
    nx_ready = 0;
    put(0, ST, 0);
    chk("pp_count", data_from_mem, 32'h20);
    chk("pp_head2", {24'b0, tx_data}, 32'h22);
    nx_ready = 1;
    put(0, 32'h2000, 0); chk("pp_out22", {24'b0, tx_data}, 32'h22);
    put(0, 32'h2000, 0); chk("pp_out55", {24'b0, tx_data}, 32'h55);
    nx_ready = 0;
    put(0, 32'h2000, 0); chk("pp_empty", {31'b0, tx_valid}, 32'h0);
    for (int i = 0; i < 4; i++) put(1, TX, 32'hA1 + 32'(i));
    nx_ready = 1;
    put(1, TX, 32'h66); chk("fullpop_head", {24'b0, tx_data}, 32'hA1);
    nx_ready = 0;
    put(0, ST, 0);
    chk("fullpop_status", data_from_mem, 32'h230);
    chk("fullpop_head2", {24'b0, tx_data}, 32'hA2);
    put(1, GPIO, 32'hCAFE);
    put(0, GPIO, 0);
    chk("gpio_pin", gpio_out, 32'hCAFE);
    chk("gpio_read", data_from_mem, 32'hCAFE);
    nx_reset = 1;
    put(0, ST, 0);
    nx_reset = 0;
    put(0, ST, 0);
    chk("midrst_valid", {31'b0, tx_valid}, 32'h0);
    chk("midrst_gpio", gpio_out, 32'h0);
    chk("midrst_status", data_from_mem, 32'h1);
    put(0, 32'h2000, 0); chk("unmapped_rd", data_from_mem, 32'h0);
    put(0, TX, 0); chk("txdata_rd", data_from_mem, 32'h0);
    put(0, 32'h100, 0); chk("past_ram_rd", data_from_mem, 32'h0);
    put(1, GPIO, 32'h77);
    put(1, 32'h2000, 32'hFFFF_FFFF);
    put(0, GPIO, 0); chk("unmapped_wr_gpio", data_from_mem, 32'h77);
    put(0, 32'h10, 0); chk("unmapped_wr_ram", data_from_mem, 32'hDEAD_BEEF);
    put(0, ST, 0); chk("unmapped_wr_status", data_from_mem, 32'h1);
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 9));
      a = r < 4 ? {24'b0, 6'($urandom), 2'b00}
        : r < 8 ? IO + {28'b0, 2'($urandom), 2'b00}
        : r == 8 ? 32'h2000 + {24'b0, 6'($urandom), 2'b00} : 32'h100;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      nx_reset = $urandom_range(0, 59) == 0;
      nx_ready = $urandom_range(0, 2) == 0;
      put(1'($urandom_range(0, 1)), a, $urandom);
    end
    put(0, 32'h2000, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
